control_subcmd_drawrect: RTL and testbench
==========================================

CONTROL_SUBCMD_DRAWRECT -- requirements
Module: control_subcmd_drawrect

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 64, panel columns.
REQ-002 SHALL have parameter PIXEL_HEIGHT, default 32, panel rows.
REQ-003 SHALL have parameter BYTES_PER_PIXEL, default 2, color bytes per pixel (1..4).
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports enable  in  1 (advance/start) and ack  in  1 (completion acknowledge).
REQ-007 SHALL have port mode  in  2  0=FILL, 1=OUTLINE, 2/3 reserved.
REQ-008 SHALL have ports x1, width  in  clog2(PIXEL_WIDTH), and y1, height  in  clog2(PIXEL_HEIGHT).
REQ-009 SHALL have port color  in  BYTES_PER_PIXEL*8  pixel value, byte aligned.
REQ-010 SHALL have outputs row, column, pixel (clog2(BYTES_PER_PIXEL), min 1) and data_out (8), giving the write address and byte.
REQ-011 SHALL have outputs ram_write_enable, ram_access_start (toggle strobe), busy, done and reject, each 1 bit.

Function
REQ-012 SHALL use states IDLE, SETUP, WRITE, DONE; IDLE&enable->SETUP, SETUP->WRITE or DONE, WRITE (last byte)->DONE, DONE&ack->IDLE.
REQ-013 SHALL latch x1, y1, width, height, mode and color on the IDLE->SETUP edge; later input changes are ignored.
REQ-014 SHALL compute in SETUP, with 1-bit-wider arithmetic, x_last=x1+width-1 and y_last=y1+height-1.
REQ-015 SHALL go SETUP->DONE with no writes when width=0, height=0, or mode is reserved; reserved mode sets reject=1.
REQ-016 SHALL emit one byte per WRITE cycle with enable=1, in raster order: row y1..y_last, column ascending, pixel BYTES_PER_PIXEL-1 down to 0.
REQ-017 SHALL drive data_out=color[pixel*8+:8] aligned with row/column/pixel, and toggle ram_access_start once per emitted byte.
REQ-018 SHALL, in OUTLINE mode, emit only pixels with row in {y1,y_last} or column in {x1,x_last}, jumping from x1 to x_last on interior rows with no idle cycle.
REQ-019 SHALL hold all outputs and not toggle ram_access_start during WRITE cycles with enable=0.
REQ-020 SHALL hold ram_write_enable=1 in WRITE only; first byte appears the cycle after SETUP.
REQ-021 SHALL hold done=1 in DONE until ack; done deasserts the cycle after ack, and enable is ignored in DONE.
REQ-022 SHALL hold busy=1 in SETUP and WRITE.

Reset
REQ-023 SHALL on reset, regardless of enable/ack, enter IDLE and zero row, column, pixel, data_out, ram_write_enable, ram_access_start, busy, done and reject, including mid-WRITE.

Configuration
REQ-024 SHALL, with DRAWRECT_CLIP_EN defined, clamp x_last to PIXEL_WIDTH-1 and y_last to PIXEL_HEIGHT-1; x1>=PIXEL_WIDTH or y1>=PIXEL_HEIGHT gives no writes and reject=1.
REQ-025 SHALL, without DRAWRECT_CLIP_EN, write nothing for any rectangle with x_last>=PIXEL_WIDTH or y_last>=PIXEL_HEIGHT and set reject=1 until the DONE->IDLE transition.

Structure
REQ-026 SHALL place the state enum, mode enum (FILL, OUTLINE) and width helper constants in package drawrect_pkg.
REQ-027 SHALL implement bound computation/clipping (REQ-014/015/024/025) in combinational sub-module drawrect_bounds.

Verification (64x32 panel, BYTES_PER_PIXEL=2, enable held high unless stated)
REQ-028 SHALL cover FILL x1=2,y1=3,w=2,h=2,color=16'hABCD -> 8 bytes (3,2,1)=AB,(3,2,0)=CD,(3,3,1)..(4,3,0); 8 toggles, then done.
REQ-029 SHALL cover OUTLINE x1=0,y1=0,w=3,h=3 -> 16 bytes, pixel (1,1) never addressed, done afterwards.
REQ-030 SHALL cover x1=62,w=4,h=1 -> with DRAWRECT_CLIP_EN columns 62,63 only (4 bytes), reject=0; without it 0 bytes, reject=1.
REQ-031 SHALL cover width=0 -> done two cycles after enable, no ram_access_start toggle, ram_write_enable never high.
REQ-032 SHALL cover enable low 3 cycles after byte 3 -> outputs frozen, no toggles, resume at byte 4; reset asserted mid-WRITE -> all outputs 0 next cycle, IDLE.
REQ-033 SHALL cover done held 5 cycles without ack with enable pulses ignored; ack -> done=0 next cycle, new command accepted.

Source files
------------

// File: rtl/drawrect_pkg.sv
// drawrect_pkg: shared types and constants for the rectangle-draw subcommand.
//   state_t      - sequencer states (IDLE, SETUP, WRITE, DONE)
//   mode_t       - drawing modes (FILL, OUTLINE); encodings 2 and 3 are reserved
//   BYTE_W       - width of one emitted colour byte
//   width_of()   - address width helper: clog2(n), never less than 1 bit
package drawrect_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        OUTLINE = 2'd1
    } mode_t;

    localparam int BYTE_W = 8;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/drawrect_bounds.sv
// drawrect_bounds: combinational bound computation for one rectangle command.
// Computes the inclusive last column/row and decides whether the command
// produces any writes at all.
// Build option: define DRAWRECT_CLIP_EN to clamp rectangles that overhang the
// panel instead of rejecting them.
// Ports:
//   mode           in  drawing mode (reserved encodings are rejected)
//   x1, width      in  first column and column count
//   y1, height     in  first row and row count
//   x_last, y_last out inclusive last column/row (valid when skip=0)
//   skip           out no bytes are to be written
//   reject         out command refused (reserved mode or out of panel)
module drawrect_bounds
    import drawrect_pkg::*;
#(
    parameter  int PIXEL_WIDTH  = 64,
    parameter  int PIXEL_HEIGHT = 32,
    localparam int CW = width_of(PIXEL_WIDTH),
    localparam int RW = width_of(PIXEL_HEIGHT)
)(
    input  logic [1:0]    mode,
    input  logic [CW-1:0] x1,
    input  logic [CW-1:0] width,
    input  logic [RW-1:0] y1,
    input  logic [RW-1:0] height,
    output logic [CW-1:0] x_last,
    output logic [RW-1:0] y_last,
    output logic          skip,
    output logic          reject
);

    localparam logic [CW:0] X_MAX = (CW+1)'(PIXEL_WIDTH - 1);
    localparam logic [RW:0] Y_MAX = (RW+1)'(PIXEL_HEIGHT - 1);

    logic [CW:0] x_end_s;
    logic [RW:0] y_end_s;

    // One extra bit keeps x1+width-1 from wrapping so overhang is detectable.
    always_comb begin
        x_end_s = {1'b0, x1} + {1'b0, width} - (CW+1)'(1);
        y_end_s = {1'b0, y1} + {1'b0, height} - (RW+1)'(1);
        x_last  = x_end_s[CW-1:0];
        y_last  = y_end_s[RW-1:0];
        skip    = 1'b0;
        reject  = 1'b0;
        if ((mode != FILL) && (mode != OUTLINE)) begin
            skip   = 1'b1;
            reject = 1'b1;
        end else if ((width == CW'(0)) || (height == RW'(0))) begin
            // Empty rectangle: nothing to draw, but not an error.
            skip   = 1'b1;
            reject = 1'b0;
`ifdef DRAWRECT_CLIP_EN
        end else if (({1'b0, x1} > X_MAX) || ({1'b0, y1} > Y_MAX)) begin
            skip   = 1'b1;
            reject = 1'b1;
        end else begin
            if (x_end_s > X_MAX) begin
                x_last = X_MAX[CW-1:0];
            end else begin
                x_last = x_end_s[CW-1:0];
            end
            if (y_end_s > Y_MAX) begin
                y_last = Y_MAX[RW-1:0];
            end else begin
                y_last = y_end_s[RW-1:0];
            end
        end
`else
        end else if ((x_end_s > X_MAX) || (y_end_s > Y_MAX)) begin
            skip   = 1'b1;
            reject = 1'b1;
        end else begin
            x_last = x_end_s[CW-1:0];
            y_last = y_end_s[RW-1:0];
        end
`endif
    end

endmodule

// File: rtl/control_subcmd_drawrect.sv
// control_subcmd_drawrect: walks a filled or outlined rectangle over the panel
// and emits one colour byte per advancing WRITE cycle (raster order, most
// significant colour byte first).
// Build option: DRAWRECT_CLIP_EN (see drawrect_bounds) clamps overhanging
// rectangles instead of rejecting them.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   enable             start command in IDLE, advance one byte in WRITE
//   ack                acknowledge completion in DONE
//   mode               0=FILL, 1=OUTLINE, 2/3 reserved (rejected)
//   x1, width, y1, height, color   command operands, latched at start
//   row, column, pixel, data_out   current write address and byte
//   ram_write_enable   high throughout WRITE
//   ram_access_start   toggles once per emitted byte
//   busy, done, reject status flags
module control_subcmd_drawrect
    import drawrect_pkg::*;
#(
    parameter  int PIXEL_WIDTH     = 64,
    parameter  int PIXEL_HEIGHT    = 32,
    parameter  int BYTES_PER_PIXEL = 2,
    localparam int CW      = width_of(PIXEL_WIDTH),
    localparam int RW      = width_of(PIXEL_HEIGHT),
    localparam int PW      = width_of(BYTES_PER_PIXEL),
    localparam int COLOR_W = BYTES_PER_PIXEL * BYTE_W
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               ack,
    input  logic [1:0]         mode,
    input  logic [CW-1:0]      x1,
    input  logic [CW-1:0]      width,
    input  logic [RW-1:0]      y1,
    input  logic [RW-1:0]      height,
    input  logic [COLOR_W-1:0] color,
    output logic [RW-1:0]      row,
    output logic [CW-1:0]      column,
    output logic [PW-1:0]      pixel,
    output logic [BYTE_W-1:0]  data_out,
    output logic               ram_write_enable,
    output logic               ram_access_start,
    output logic               busy,
    output logic               done,
    output logic               reject
);

    localparam logic [PW-1:0] PIX_TOP = PW'(BYTES_PER_PIXEL - 1);

    state_t             state_r;
    logic [CW-1:0]      x1_r;
    logic [CW-1:0]      width_r;
    logic [RW-1:0]      y1_r;
    logic [RW-1:0]      height_r;
    logic [1:0]         mode_r;
    logic [COLOR_W-1:0] color_r;

    logic [CW-1:0]      x_last_s;
    logic [RW-1:0]      y_last_s;
    logic               skip_s;
    logic               reject_s;

    logic [RW-1:0]      next_row_s;
    logic [CW-1:0]      next_col_s;
    logic [PW-1:0]      next_pix_s;
    logic               last_byte_s;
    logic               edge_row_s;

    function automatic logic [BYTE_W-1:0] color_byte(
        input logic [COLOR_W-1:0] c,
        input logic [PW-1:0]      p
    );
        return c[int'(p) * BYTE_W +: BYTE_W];
    endfunction

    drawrect_bounds #(
        .PIXEL_WIDTH  (PIXEL_WIDTH),
        .PIXEL_HEIGHT (PIXEL_HEIGHT)
    ) u_bounds (
        .mode   (mode_r),
        .x1     (x1_r),
        .width  (width_r),
        .y1     (y1_r),
        .height (height_r),
        .x_last (x_last_s),
        .y_last (y_last_s),
        .skip   (skip_s),
        .reject (reject_s)
    );

    // Next byte address; interior OUTLINE rows jump straight from x1 to x_last.
    always_comb begin
        next_row_s  = row;
        next_col_s  = column;
        next_pix_s  = pixel;
        last_byte_s = 1'b0;
        edge_row_s  = (row == y1_r) || (row == y_last_s);
        if (pixel != PW'(0)) begin
            next_pix_s = pixel - PW'(1);
        end else begin
            next_pix_s = PIX_TOP;
            if (column == x_last_s) begin
                if (row == y_last_s) begin
                    last_byte_s = 1'b1;
                end else begin
                    next_row_s = row + RW'(1);
                    next_col_s = x1_r;
                end
            end else if ((mode_r == OUTLINE) && !edge_row_s && (column == x1_r)) begin
                next_col_s = x_last_s;
            end else begin
                next_col_s = column + CW'(1);
            end
        end
    end

    // Command sequencer with registered address, data and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= IDLE;
            x1_r             <= CW'(0);
            width_r          <= CW'(0);
            y1_r             <= RW'(0);
            height_r         <= RW'(0);
            mode_r           <= 2'd0;
            color_r          <= COLOR_W'(0);
            row              <= RW'(0);
            column           <= CW'(0);
            pixel            <= PW'(0);
            data_out         <= BYTE_W'(0);
            ram_write_enable <= 1'b0;
            ram_access_start <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            reject           <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (enable) begin
                        x1_r     <= x1;
                        width_r  <= width;
                        y1_r     <= y1;
                        height_r <= height;
                        mode_r   <= mode;
                        color_r  <= color;
                        busy     <= 1'b1;
                        reject   <= 1'b0;
                        state_r  <= SETUP;
                    end
                end
                SETUP: begin
                    if (skip_s) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        reject  <= reject_s;
                        state_r <= DONE;
                    end else begin
                        // Present the first byte immediately on entering WRITE.
                        row              <= y1_r;
                        column           <= x1_r;
                        pixel            <= PIX_TOP;
                        data_out         <= color_byte(color_r, PIX_TOP);
                        ram_write_enable <= 1'b1;
                        ram_access_start <= ~ram_access_start;
                        state_r          <= WRITE;
                    end
                end
                WRITE: begin
                    // The presented byte is consumed on each enabled cycle.
                    if (enable) begin
                        if (last_byte_s) begin
                            ram_write_enable <= 1'b0;
                            busy             <= 1'b0;
                            done             <= 1'b1;
                            state_r          <= DONE;
                        end else begin
                            row              <= next_row_s;
                            column           <= next_col_s;
                            pixel            <= next_pix_s;
                            data_out         <= color_byte(color_r, next_pix_s);
                            ram_access_start <= ~ram_access_start;
                        end
                    end
                end
                DONE: begin
                    if (ack) begin
                        done    <= 1'b0;
                        reject  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r          <= IDLE;
                    ram_write_enable <= 1'b0;
                    busy             <= 1'b0;
                    done             <= 1'b0;
                    reject           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_subcmd_drawrect.sv
// Directed testbench for control_subcmd_drawrect on a 64x32 panel, 2 bytes/pixel.
module tb_control_subcmd_drawrect;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        ack;
    logic [1:0]  mode;
    logic [5:0]  x1;
    logic [5:0]  width;
    logic [4:0]  y1;
    logic [4:0]  height;
    logic [15:0] color;
    logic [4:0]  row;
    logic [5:0]  column;
    logic [0:0]  pixel;
    logic [7:0]  data_out;
    logic        ram_write_enable;
    logic        ram_access_start;
    logic        busy;
    logic        done;
    logic        reject;

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [31:0] cap_q[$];
    logic [31:0] exp_q[$];
    int          toggles_cnt = 0;
    int          we_cycles   = 0;
    logic        ras_prev    = 1'b0;

    control_subcmd_drawrect #(
        .PIXEL_WIDTH     (64),
        .PIXEL_HEIGHT    (32),
        .BYTES_PER_PIXEL (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .ack              (ack),
        .mode             (mode),
        .x1               (x1),
        .width            (width),
        .y1               (y1),
        .height           (height),
        .color            (color),
        .row              (row),
        .column           (column),
        .pixel            (pixel),
        .data_out         (data_out),
        .ram_write_enable (ram_write_enable),
        .ram_access_start (ram_access_start),
        .busy             (busy),
        .done             (done),
        .reject           (reject)
    );

    always #5 clk = ~clk;

    // Byte monitor: a byte is consumed when presented with enable high.
    initial begin
        forever begin
            @(negedge clk);
            if (ram_write_enable && enable) begin
                cap_q.push_back({8'(row), 8'(column), 8'(pixel), data_out});
            end
            if (ram_write_enable) we_cycles++;
            if (ram_access_start != ras_prev) toggles_cnt++;
            ras_prev = ram_access_start;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_capture();
        cap_q.delete();
        toggles_cnt = 0;
        we_cycles   = 0;
    endtask

    task automatic start_cmd(input logic [1:0] m, input int x, input int y,
                             input int w, input int h, input logic [15:0] c);
        mode   = m;
        x1     = 6'(x);
        y1     = 5'(y);
        width  = 6'(w);
        height = 5'(h);
        color  = c;
        enable = 1'b1;
        clear_capture();
    endtask

    // Reference model: visit every cell of the rectangle, keep outline cells.
    task automatic build_expected(input logic [1:0] m, input int x, input int y,
                                  input int w, input int h, input logic [15:0] c);
        int xl;
        int yl;
        exp_q.delete();
        if (m > 2'd1 || w == 0 || h == 0) return;
        xl = x + w - 1;
        yl = y + h - 1;
`ifdef DRAWRECT_CLIP_EN
        if (x >= 64 || y >= 32) return;
        if (xl > 63) xl = 63;
        if (yl > 31) yl = 31;
`else
        if (xl > 63 || yl > 31) return;
`endif
        for (int r = y; r <= yl; r++) begin
            for (int col = x; col <= xl; col++) begin
                if (m == 2'd1 && r != y && r != yl && col != x && col != xl) continue;
                for (int p = 1; p >= 0; p--) begin
                    exp_q.push_back({8'(r), 8'(col), 8'(p), c[p*8 +: 8]});
                end
            end
        end
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (done) break;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic compare_bytes(input string tag);
        check({tag, "_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            check({tag, "_byte"}, cap_q[i], exp_q[i]);
        end
    endtask

    task automatic ack_done();
        ack    = 1'b1;
        enable = 1'b0;
        tick();
        check("ack_done_clear", 32'(done), 32'd0);
        ack = 1'b0;
    endtask

    initial begin
        int hits;
        reset  = 1'b1;
        enable = 1'b0;
        ack    = 1'b0;
        mode   = 2'd0;
        x1     = 6'd0;
        y1     = 5'd0;
        width  = 6'd0;
        height = 5'd0;
        color  = 16'h0000;
        tick();
        tick();
        check("reset_outs", {row, column, pixel, data_out, ram_write_enable,
                             ram_access_start, busy, done, reject}, 32'd0);
        reset = 1'b0;
        tick();

        // FILL 2x2 at (2,3)
        start_cmd(2'd0, 2, 3, 2, 2, 16'hABCD);
        build_expected(2'd0, 2, 3, 2, 2, 16'hABCD);
        tick();
        check("fill_busy", 32'(busy), 32'd1);
        wait_done("fill");
        compare_bytes("fill");
        check("fill_first", cap_q[0], {8'd3, 8'd2, 8'd1, 8'hAB});
        check("fill_second", cap_q[1], {8'd3, 8'd2, 8'd0, 8'hCD});
        check("fill_last", cap_q[7], {8'd4, 8'd3, 8'd0, 8'hCD});
        check("fill_toggles", 32'(toggles_cnt), 32'd8);
        check("fill_reject", 32'(reject), 32'd0);
        check("fill_we_off", 32'(ram_write_enable), 32'd0);
        ack_done();

        // OUTLINE 3x3 at origin
        start_cmd(2'd1, 0, 0, 3, 3, 16'h1234);
        build_expected(2'd1, 0, 0, 3, 3, 16'h1234);
        wait_done("outline");
        compare_bytes("outline");
        check("outline_nbytes", 32'(cap_q.size()), 32'd16);
        hits = 0;
        foreach (cap_q[i]) if (cap_q[i][31:24] == 8'd1 && cap_q[i][23:16] == 8'd1) hits++;
        check("outline_center", 32'(hits), 32'd0);
        check("outline_we_cycles", 32'(we_cycles), 32'd16);
        ack_done();

        // Overhanging rectangle at right edge
        start_cmd(2'd0, 62, 5, 4, 1, 16'h5AA5);
        build_expected(2'd0, 62, 5, 4, 1, 16'h5AA5);
        wait_done("edge");
        compare_bytes("edge");
`ifdef DRAWRECT_CLIP_EN
        check("edge_nbytes", 32'(cap_q.size()), 32'd4);
        check("edge_reject", 32'(reject), 32'd0);
`else
        check("edge_nbytes", 32'(cap_q.size()), 32'd0);
        check("edge_reject", 32'(reject), 32'd1);
        check("edge_toggles", 32'(toggles_cnt), 32'd0);
`endif
        ack_done();
        check("edge_reject_clear", 32'(reject), 32'd0);

        // Zero width
        start_cmd(2'd0, 4, 4, 0, 3, 16'hFFFF);
        tick();
        check("zero_w_done_early", 32'(done), 32'd0);
        check("zero_w_busy", 32'(busy), 32'd1);
        tick();
        check("zero_w_done", 32'(done), 32'd1);
        check("zero_w_reject", 32'(reject), 32'd0);
        tick();
        check("zero_w_toggles", 32'(toggles_cnt), 32'd0);
        check("zero_w_we", 32'(we_cycles), 32'd0);
        ack_done();

        // Stall after byte 3, then resume
        start_cmd(2'd0, 2, 3, 2, 2, 16'hABCD);
        build_expected(2'd0, 2, 3, 2, 2, 16'hABCD);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (cap_q.size() == 3) break;
        end
        check("stall_reach", 32'(cap_q.size()), 32'd3);
        enable = 1'b0;
        tick();
        tick();
        tick();
        check("stall_addr", {8'(row), 8'(column), 8'(pixel), data_out}, {8'd3, 8'd3, 8'd0, 8'hCD});
        check("stall_nbytes", 32'(cap_q.size()), 32'd3);
        check("stall_toggles", 32'(toggles_cnt), 32'd4);
        check("stall_we", 32'(ram_write_enable), 32'd1);
        enable = 1'b1;
        wait_done("stall");
        compare_bytes("stall");
        check("stall_total_toggles", 32'(toggles_cnt), 32'd8);
        ack_done();

        // Reset in the middle of WRITE
        start_cmd(2'd0, 10, 10, 3, 3, 16'h7788);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (cap_q.size() == 2) break;
        end
        check("midrst_reach", 32'(ram_write_enable), 32'd1);
        reset = 1'b1;
        tick();
        check("midrst_outs", {row, column, pixel, data_out, ram_write_enable,
                              ram_access_start, busy, done, reject}, 32'd0);
        reset  = 1'b0;
        enable = 1'b0;
        tick();
        check("midrst_idle", {busy, done, ram_write_enable}, 32'd0);

        // DONE hold without ack, enable pulses ignored
        start_cmd(2'd0, 5, 6, 1, 1, 16'h1234);
        build_expected(2'd0, 5, 6, 1, 1, 16'h1234);
        wait_done("hold");
        compare_bytes("hold");
        for (int i = 0; i < 5; i++) begin
            enable = (i % 2) == 0;
            tick();
            check("hold_done", {done, busy, ram_write_enable}, 32'b100);
        end
        check("hold_nbytes", 32'(cap_q.size()), 32'd2);
        ack_done();

        // New command accepted: reserved mode is rejected
        start_cmd(2'd2, 1, 1, 2, 2, 16'h4321);
        tick();
        check("reserved_busy", 32'(busy), 32'd1);
        wait_done("reserved");
        check("reserved_reject", 32'(reject), 32'd1);
        check("reserved_nbytes", 32'(cap_q.size()), 32'd0);
        ack_done();
        check("reserved_reject_clear", 32'(reject), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
